fruit_trajectory: RTL and testbench

Per-fruit motion controller that produces the sprite's top-left screen coordinate consumed by the fruit image lookup stage, which computes pixel address = (x − fruit_x) + 50·(y − fruit_y). On a launch request it throws a 50×50 fruit upward from the bottom of the 640×480 screen. It then integrates velocity and gravity once per video frame, bounces off side walls, reacts to slices, and retires the fruit when it falls off the bottom. Coordinates change only on `frame_tick`, so they are stable during active video.

---
 rtl/fruit_trajectory.sv | 212 +++++++++++++++++++++
 tb/tb_fruit_trajectory.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fruit_trajectory.sv
// fruit_trajectory: per-fruit motion controller.
// Launches a 50x50 sprite from the bottom of a 640x480 screen. Once per video
// frame it integrates velocity and gravity, bounces off the side walls, clamps
// at the ceiling, reacts to slices and retires the fruit when it drops off the
// bottom. The coordinates change only on frame_tick (vertical blanking) or on
// a launch, so they are stable for the image lookup during active video.
module fruit_trajectory #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int SPRITE_SIZE = 50,
    parameter int LAUNCH_Y    = 430,
    parameter int GRAVITY     = 1,
    parameter int VY_MAX      = 15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic [9:0] launch_x,
    input  logic [5:0] launch_vx,
    input  logic [5:0] launch_vy,
    input  logic       slice,
    output logic [9:0] fruit_x,
    output logic [8:0] fruit_y,
    output logic       active,
    output logic       sliced,
    output logic       missed
);

    // Bounds expressed in the signed 12-bit position domain.
    localparam logic signed [11:0] X_MAX_S    = 12'(SCREEN_W - SPRITE_SIZE);
    localparam logic signed [11:0] SCREEN_H_S = 12'(SCREEN_H);
    localparam logic signed [11:0] LAUNCH_Y_S = 12'(LAUNCH_Y);
    localparam logic signed [6:0]  GRAVITY_S  = 7'(GRAVITY);
    localparam logic signed [6:0]  VY_MAX_S   = 7'(VY_MAX);
    localparam logic signed [5:0]  VEL_MIN_S  = -6'sd32;
    localparam logic signed [5:0]  VEL_POS_S  = 6'sd31;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLYING = 2'd1,
        S_SLICED = 2'd2
    } state_t;

    state_t             r_state;
    logic signed [11:0] r_px;
    logic signed [11:0] r_py;
    logic signed [5:0]  r_vx;
    logic signed [5:0]  r_vy;
    logic               r_active;
    logic               r_sliced;
    logic               r_missed;

    logic signed [11:0] w_npx;
    logic signed [11:0] w_npy;
    logic signed [11:0] w_px_tick;
    logic signed [11:0] w_py_tick;
    logic signed [5:0]  w_vx_neg;
    logic signed [5:0]  w_vx_tick;
    logic signed [6:0]  w_vy_inc;
    logic signed [5:0]  w_vy_grav;
    logic signed [5:0]  w_vy_tick;
    logic signed [5:0]  w_vy_slice;
    logic signed [5:0]  w_vy_slice_tick;
    logic               w_exit;
    logic signed [11:0] w_launch_x_ext;
    logic signed [11:0] w_launch_px;

    // Per-frame physics candidates, all computed from the pre-tick velocities.
    // NOTE: every signal driven here gets a value on every path (defaults
    // first), so no latch can be inferred.
    always_comb begin
        w_npx           = r_px + {{6{r_vx[5]}}, r_vx};
        w_npy           = r_py + {{6{r_vy[5]}}, r_vy};
        w_px_tick       = w_npx;
        w_py_tick       = w_npy;
        w_vx_tick       = r_vx;
        w_vy_tick       = '0;
        w_vy_slice_tick = '0;

        // Bounce reverses vx; -32 has no positive twin so it saturates to +31.
        w_vx_neg = (r_vx == VEL_MIN_S) ? VEL_POS_S : -r_vx;

        if (w_npx < 12'sd0) begin
            w_px_tick = 12'sd0;
            w_vx_tick = w_vx_neg;
        end else if (w_npx > X_MAX_S) begin
            w_px_tick = X_MAX_S;
            w_vx_tick = w_vx_neg;
        end

        // Gravity with terminal velocity; 7 bits so vy = +31 cannot wrap.
        w_vy_inc  = {r_vy[5], r_vy} + GRAVITY_S;
        w_vy_grav = (w_vy_inc > VY_MAX_S) ? VY_MAX_S[5:0] : w_vy_inc[5:0];

        if (w_npy < 12'sd0) begin
            // Ceiling: pin to the top edge and kill the vertical motion.
            w_py_tick = 12'sd0;
            w_vy_tick = '0;
        end else begin
            w_vy_tick = w_vy_grav;
        end

        // A slice arriving with a tick keeps gravity but never moves upward.
        w_vy_slice_tick = w_vy_grav[5] ? 6'sd0 : w_vy_grav;

        w_exit = (w_npy >= SCREEN_H_S);
    end

    // Slice velocity without a tick, and the launch x clamp.
    always_comb begin
        w_vy_slice     = r_vy[5] ? 6'sd0 : r_vy;
        w_launch_x_ext = {2'b00, launch_x};
        w_launch_px    = (w_launch_x_ext > X_MAX_S) ? X_MAX_S : w_launch_x_ext;
    end

    // Fruit FSM: launch, per-frame motion, slice and exit, registered outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: reset is synchronous and clears every state register;
            // an aborted flight therefore never produces a missed pulse.
            r_state  <= S_IDLE;
            r_px     <= '0;
            r_py     <= '0;
            r_vx     <= '0;
            r_vy     <= '0;
            r_active <= 1'b0;
            r_sliced <= 1'b0;
            r_missed <= 1'b0;
        end else begin
            r_missed <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A tick in the same cycle is ignored; motion starts on
                    // the next tick after the launch is loaded.
                    if (launch) begin
                        r_state  <= S_FLYING;
                        r_px     <= w_launch_px;
                        r_py     <= LAUNCH_Y_S;
                        r_vx     <= launch_vx;
                        r_vy     <= launch_vy;
                        r_active <= 1'b1;
                        r_sliced <= 1'b0;
                    end
                end

                S_FLYING: begin
                    if (frame_tick) begin
                        if (w_exit) begin
                            r_state  <= S_IDLE;
                            r_vx     <= '0;
                            r_vy     <= '0;
                            r_active <= 1'b0;
                            r_sliced <= 1'b0;
                            r_missed <= 1'b1;
                        end else begin
                            r_px <= w_px_tick;
                            r_py <= w_py_tick;
                            if (slice) begin
                                r_state  <= S_SLICED;
                                r_vx     <= '0;
                                r_vy     <= w_vy_slice_tick;
                                r_sliced <= 1'b1;
                            end else begin
                                r_vx <= w_vx_tick;
                                r_vy <= w_vy_tick;
                            end
                        end
                    end else if (slice) begin
                        r_state  <= S_SLICED;
                        r_vx     <= '0;
                        r_vy     <= w_vy_slice;
                        r_sliced <= 1'b1;
                    end
                end

                S_SLICED: begin
                    if (frame_tick) begin
                        if (w_exit) begin
                            // Sliced fruit leaving the screen is not a miss.
                            r_state  <= S_IDLE;
                            r_vx     <= '0;
                            r_vy     <= '0;
                            r_active <= 1'b0;
                            r_sliced <= 1'b0;
                        end else begin
                            r_px <= w_px_tick;
                            r_py <= w_py_tick;
                            r_vx <= w_vx_tick;
                            r_vy <= w_vy_tick;
                        end
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_active <= 1'b0;
                    r_sliced <= 1'b0;
                end
            endcase
        end
    end

    assign fruit_x = r_px[9:0];
    assign fruit_y = r_py[8:0];
    assign active  = r_active;
    assign sliced  = r_sliced;
    assign missed  = r_missed;

endmodule

// File: tb/tb_fruit_trajectory.sv
// tb_fruit_trajectory: directed test-plan scenarios followed by randomized
// traffic, every cycle compared against an integer reference model.
module tb_fruit_trajectory;

    logic       clk;
    logic       resetn;
    logic       frame_tick;
    logic       launch;
    logic [9:0] launch_x;
    logic [5:0] launch_vx;
    logic [5:0] launch_vy;
    logic       slice;
    logic [9:0] fruit_x;
    logic [8:0] fruit_y;
    logic       active;
    logic       sliced;
    logic       missed;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, plain integers.
    int  m_px, m_py, m_vx, m_vy;
    bit  m_active, m_sliced, m_missed;
    int  miss_seen;

    fruit_trajectory dut (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .launch     (launch),
        .launch_x   (launch_x),
        .launch_vx  (launch_vx),
        .launch_vy  (launch_vy),
        .slice      (slice),
        .fruit_x    (fruit_x),
        .fruit_y    (fruit_y),
        .active     (active),
        .sliced     (sliced),
        .missed     (missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int neg_sat(input int v);
        return (v == -32) ? 31 : -v;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_px = 0; m_py = 0; m_vx = 0; m_vy = 0;
        m_active = 0; m_sliced = 0; m_missed = 0;
    endtask

    // One clock edge of the behavioural rules.
    task automatic model_step(input bit l, input int lx, input int lvx, input int lvy,
                              input bit s, input bit t);
        int npx, npy, nvx, nvy;
        m_missed = 0;
        if (!m_active) begin
            if (l) begin
                m_px = imin(lx, 590);
                m_py = 430;
                m_vx = lvx;
                m_vy = lvy;
                m_active = 1;
                m_sliced = 0;
            end
        end else if (t) begin
            npx = m_px + m_vx;
            npy = m_py + m_vy;
            if (npy >= 480) begin
                m_missed = !m_sliced;
                m_active = 0;
                m_sliced = 0;
            end else begin
                if (npx < 0)        begin m_px = 0;   nvx = neg_sat(m_vx); end
                else if (npx > 590) begin m_px = 590; nvx = neg_sat(m_vx); end
                else                begin m_px = npx; nvx = m_vx;          end
                if (npy < 0) begin m_py = 0;   nvy = 0; end
                else         begin m_py = npy; nvy = imin(m_vy + 1, 15); end
                if (s && !m_sliced) begin
                    m_vx = 0;
                    m_vy = imax(imin(m_vy + 1, 15), 0);
                    m_sliced = 1;
                end else begin
                    m_vx = nvx;
                    m_vy = nvy;
                end
            end
        end else if (s && !m_sliced) begin
            m_vx = 0;
            m_vy = imax(m_vy, 0);
            m_sliced = 1;
        end
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, "_x"},      32'(fruit_x), 32'(m_px));
        check({tag, "_y"},      32'(fruit_y), 32'(m_py));
        check({tag, "_active"}, 32'(active),  32'(m_active));
        check({tag, "_sliced"}, 32'(sliced),  32'(m_sliced));
        check({tag, "_missed"}, 32'(missed),  32'(m_missed));
        if (missed) miss_seen++;
    endtask

    // Drive one cycle at the falling edge, check #1 after the rising edge.
    task automatic cyc(input string tag, input bit l, input int lx, input int lvx,
                       input int lvy, input bit s, input bit t);
        @(negedge clk);
        launch     = l;
        launch_x   = 10'(lx);
        launch_vx  = 6'(lvx);
        launch_vy  = 6'(lvy);
        slice      = s;
        frame_tick = t;
        model_step(l, lx, lvx, lvy, s, t);
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc("idle", 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 1);
        idle(2);
    endtask

    task automatic do_launch(input int lx, input int lvx, input int lvy);
        cyc("launch", 1, lx, lvx, lvy, 0, 0);
        idle(1);
    endtask

    // Tick until the fruit retires, bounded.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (active && n < 200) begin
            tick(tag);
            n++;
        end
        check({tag, "_drained"}, 32'(active), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0;
        frame_tick = 1'b1;
        launch = 1'b0;
        slice = 1'b0;
        model_reset();
        @(posedge clk); #1;
        compare_outputs("rst1");
        @(negedge clk);
        @(posedge clk); #1;
        compare_outputs("rst2");
        @(negedge clk);
        resetn = 1'b1;
        frame_tick = 1'b0;
    endtask

    int x_saved;
    int y_min;

    initial begin
        resetn = 1'b0; frame_tick = 0; launch = 0; slice = 0;
        launch_x = '0; launch_vx = '0; launch_vy = '0;
        miss_seen = 0;
        model_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) tick("rst_tick");
        check("rst_active_const", 32'(active), 32'd0);

        // Basic flight.
        do_launch(100, 3, -10);
        check("l0_x", 32'(fruit_x), 32'd100);
        check("l0_y", 32'(fruit_y), 32'd430);
        tick("t1"); check("t1_xy", {22'd0, fruit_x} * 1000 + 32'(fruit_y), 32'd103420);
        tick("t2"); check("t2_xy", {22'd0, fruit_x} * 1000 + 32'(fruit_y), 32'd106411);
        tick("t3"); check("t3_xy", {22'd0, fruit_x} * 1000 + 32'(fruit_y), 32'd109403);
        cyc("relaunch", 1, 500, -5, -20, 0, 0);
        check("relaunch_x", 32'(fruit_x), 32'd109);
        drain("basic");

        // Right wall.
        do_launch(588, 5, -5);
        tick("rw1"); check("rw1_x", 32'(fruit_x), 32'd590);
        tick("rw2"); check("rw2_x", 32'(fruit_x), 32'd585);
        drain("rw");

        // Left wall with -32 saturating to +31.
        do_launch(10, -32, -5);
        tick("lw1"); check("lw1_x", 32'(fruit_x), 32'd0);
        tick("lw2"); check("lw2_x", 32'(fruit_x), 32'd31);
        drain("lw");

        // Launch x clamp.
        do_launch(1000, 0, -3);
        check("clamp_x", 32'(fruit_x), 32'd590);
        drain("clamp");

        // Miss.
        do_launch(200, 0, 0);
        for (int n = 1; n <= 10; n++) begin
            tick("miss_fall");
            check("miss_fall_y", 32'(fruit_y), 32'(430 + n * (n - 1) / 2));
        end
        cyc("miss_exit", 0, 0, 0, 0, 0, 1);
        check("miss_pulse", 32'(missed), 32'd1);
        check("miss_active", 32'(active), 32'd0);
        check("miss_hold_y", 32'(fruit_y), 32'd475);
        idle(1);
        check("miss_one_cycle", 32'(missed), 32'd0);

        // Slice after two ticks.
        do_launch(300, 4, -10);
        tick("sl1"); tick("sl2");
        cyc("slice", 0, 0, 0, 0, 1, 0);
        check("slice_flag", 32'(sliced), 32'd1);
        x_saved = 308;
        check("slice_x", 32'(fruit_x), 32'(x_saved));
        miss_seen = 0;
        tick("sl3");
        check("sl3_x_frozen", 32'(fruit_x), 32'(x_saved));
        check("sl3_y_norise", 32'(fruit_y), 32'd411);
        drain("slice");
        check("slice_no_miss", 32'(miss_seen), 32'd0);

        // Ceiling.
        do_launch(300, 0, -32);
        y_min = 1000;
        for (int n = 0; n < 60 && active; n++) begin
            tick("ceil");
            if (active && int'(fruit_y) < y_min) y_min = int'(fruit_y);
        end
        check("ceil_min_y", 32'(y_min), 32'd0);
        drain("ceil");

        // Slice on the same cycle as a tick.
        do_launch(100, 3, -10);
        tick("st1");
        cyc("st_slice_tick", 0, 0, 0, 0, 1, 1);
        check("st_x_oldvel", 32'(fruit_x), 32'd106);
        check("st_sliced", 32'(sliced), 32'd1);
        idle(2);
        tick("st3");
        check("st3_x_same", 32'(fruit_x), 32'd106);
        drain("st");

        // Launch and tick together while idle: tick ignored.
        cyc("lt", 1, 50, 2, -4, 0, 1);
        check("lt_y", 32'(fruit_y), 32'd430);
        check("lt_x", 32'(fruit_x), 32'd50);

        // Reset mid-flight.
        tick("pre_rst");
        apply_reset();
        check("midrst_missed", 32'(missed), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            cyc("rnd",
                ($urandom_range(0, 19) == 0),
                int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 63)) - 32,
                int'($urandom_range(0, 46)) - 32,
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
